// File: rtl/sr_seq_pkg.sv
// Shared definitions for the SR latch sequencer.
// Holds the 3-bit FSM state encodings, the operation codes carried on
// req*_op, and a helper that turns a cycle count into a counter reload value.
package sr_seq_pkg;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_SETUP = 3'd1;
    localparam logic [2:0] ST_PULSE = 3'd2;
    localparam logic [2:0] ST_HOLD  = 3'd3;
    localparam logic [2:0] ST_CHECK = 3'd4;
    localparam logic [2:0] ST_GAP   = 3'd5;

    localparam logic OP_SET   = 1'b1;
    localparam logic OP_RESET = 1'b0;

    // The counter counts down to zero, so a state lasting w cycles loads w-1.
    function automatic logic [3:0] load_count(input int unsigned w);
        return 4'(w - 1);
    endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter.
// Ports:
//   req[1:0]   - request lines (requester valids)
//   last_grant - index of the requester granted most recently
//   gnt[1:0]   - one-hot grant, all zero when nothing is requested
//   gnt_id     - index of the granted requester (0 when nothing requested)
module rr_arb2 (
    input  logic [1:0] req,
    input  logic       last_grant,
    output logic [1:0] gnt,
    output logic       gnt_id
);

    always_comb begin
        gnt    = 2'b00;
        gnt_id = 1'b0;
        if (req == 2'b11) begin
            // Contention: the requester that was not served last wins.
            gnt_id = ~last_grant;
        end else begin
            gnt_id = req[1];
        end
        if (req != 2'b00) begin
            gnt = gnt_id ? 2'b10 : 2'b01;
        end
    end

endmodule

// File: rtl/sr_latch_sequencer.sv
// Sequencer that drives a gated SR latch on behalf of two requesters.
// Each accepted command walks SETUP -> PULSE -> HOLD -> CHECK -> GAP and the
// latch output is compared against the requested value before completion.
// Ports:
//   clk, rst                 - rising-edge clock, async active-high reset
//   req0_valid/op/ready      - requester 0 command handshake (op: 1=set, 0=reset)
//   req1_valid/op/ready      - requester 1 command handshake
//   S, R, Enable             - registered drive to the gated SR latch
//   Qa                       - latch output feedback
//   busy                     - high whenever the FSM is not idle
//   done, done_id            - one-cycle completion pulse and its requester index
//   err                      - sticky flag, latch did not reach the requested value
module sr_latch_sequencer
    import sr_seq_pkg::*;
#(
    parameter int unsigned SETUP_W = 1,
    parameter int unsigned PULSE_W = 2,
    parameter int unsigned GAP_W   = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic req0_valid,
    input  logic req0_op,
    output logic req0_ready,
    input  logic req1_valid,
    input  logic req1_op,
    output logic req1_ready,
    output logic S,
    output logic R,
    output logic Enable,
    input  logic Qa,
    output logic busy,
    output logic done,
    output logic done_id,
    output logic err
);

    logic [2:0] state, state_n;
    logic [3:0] cnt, cnt_n;
    logic       op, op_n;
    logic       id, id_n;
    logic       last_grant, last_grant_n;
    logic [1:0] gnt;
    logic       gnt_id;
    logic       idle;
    logic       take;
    logic       drive_sr_n;

    rr_arb2 u_arb (
        .req        ({req1_valid, req0_valid}),
        .last_grant (last_grant),
        .gnt        (gnt),
        .gnt_id     (gnt_id)
    );

    assign idle       = (state == ST_IDLE);
    assign req0_ready = idle & gnt[0];
    assign req1_ready = idle & gnt[1];
    assign take       = idle & (gnt != 2'b00);

    always_comb begin
        state_n      = state;
        cnt_n        = cnt;
        op_n         = op;
        id_n         = id;
        last_grant_n = last_grant;
        case (state)
            ST_IDLE: begin
                if (take) begin
                    state_n      = ST_SETUP;
                    cnt_n        = load_count(SETUP_W);
                    op_n         = gnt_id ? req1_op : req0_op;
                    id_n         = gnt_id;
                    last_grant_n = gnt_id;
                end
            end
            ST_SETUP: begin
                if (cnt == 4'd0) begin
                    state_n = ST_PULSE;
                    cnt_n   = load_count(PULSE_W);
                end else begin
                    cnt_n = cnt - 4'd1;
                end
            end
            ST_PULSE: begin
                if (cnt == 4'd0) begin
                    state_n = ST_HOLD;
                    cnt_n   = 4'd0;
                end else begin
                    cnt_n = cnt - 4'd1;
                end
            end
            ST_HOLD: begin
                state_n = ST_CHECK;
                cnt_n   = 4'd0;
            end
            ST_CHECK: begin
                state_n = ST_GAP;
                cnt_n   = load_count(GAP_W);
            end
            ST_GAP: begin
                if (cnt == 4'd0) begin
                    state_n = ST_IDLE;
                    cnt_n   = 4'd0;
                end else begin
                    cnt_n = cnt - 4'd1;
                end
            end
            default: begin
                state_n = ST_IDLE;
                cnt_n   = 4'd0;
            end
        endcase
    end

    // Outputs are decoded from the next state so that they are registered
    // yet line up with the state they belong to.
    assign drive_sr_n = (state_n == ST_SETUP) || (state_n == ST_PULSE) ||
                        (state_n == ST_HOLD);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ST_IDLE;
            cnt        <= 4'd0;
            op         <= OP_RESET;
            id         <= 1'b0;
            last_grant <= 1'b1;
            S          <= 1'b0;
            R          <= 1'b0;
            Enable     <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            done_id    <= 1'b0;
            err        <= 1'b0;
        end else begin
            state      <= state_n;
            cnt        <= cnt_n;
            op         <= op_n;
            id         <= id_n;
            last_grant <= last_grant_n;
            S          <= drive_sr_n & op_n;
            R          <= drive_sr_n & ~op_n;
            Enable     <= (state_n == ST_PULSE);
            busy       <= (state_n != ST_IDLE);
            done       <= (state_n == ST_CHECK);
            if (state_n == ST_CHECK) begin
                done_id <= id;
            end
            // Qa has been stable since Enable fell in HOLD; sampling it on the
            // HOLD->CHECK edge lets err rise together with done.
            err <= err | ((state_n == ST_CHECK) && (Qa != op));
        end
    end

endmodule

// File: tb/tb_sr_latch_sequencer.sv
module tb_sr_latch_sequencer;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic req0_valid = 1'b0, req0_op = 1'b0, req1_valid = 1'b0, req1_op = 1'b0;
    logic req0_ready, req1_ready, S, R, Enable, busy, done, done_id, err;
    logic Qa = 1'b0;
    logic stuck0 = 1'b0;

    logic b_req0_valid = 1'b0, b_req0_op = 1'b0, b_req1_valid = 1'b0, b_req1_op = 1'b0;
    logic b_req0_ready, b_req1_ready, b_S, b_R, b_Enable, b_busy, b_done, b_done_id, b_err;
    logic b_Qa = 1'b0;

    int checks = 0;
    int errors = 0;

    sr_latch_sequencer dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_op(req0_op), .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_op(req1_op), .req1_ready(req1_ready),
        .S(S), .R(R), .Enable(Enable), .Qa(Qa),
        .busy(busy), .done(done), .done_id(done_id), .err(err)
    );

    sr_latch_sequencer #(.SETUP_W(3), .PULSE_W(1), .GAP_W(1)) dut2 (
        .clk(clk), .rst(rst),
        .req0_valid(b_req0_valid), .req0_op(b_req0_op), .req0_ready(b_req0_ready),
        .req1_valid(b_req1_valid), .req1_op(b_req1_op), .req1_ready(b_req1_ready),
        .S(b_S), .R(b_R), .Enable(b_Enable), .Qa(b_Qa),
        .busy(b_busy), .done(b_done), .done_id(b_done_id), .err(b_err)
    );

    // Behavioural gated SR latch: transparent while Enable is high.
    // stuck0 models a latch whose output cannot leave 0.
    always @(negedge clk) begin
        if (Enable) begin
            if (stuck0) Qa <= 1'b0;
            else if (S && !R) Qa <= 1'b1;
            else if (R && !S) Qa <= 1'b0;
        end
        if (b_Enable) begin
            if (b_S && !b_R) b_Qa <= 1'b1;
            else if (b_R && !b_S) b_Qa <= 1'b0;
        end
    end

    always @(negedge clk) begin
        assert (!(S && R)) else $error("S and R both high on dut");
        assert (!(b_S && b_R)) else $error("S and R both high on dut2");
    end

    // Reference timeline of one operation: off = cycles since the handshake.
    // Returns {S, R, Enable, done}.
    function automatic logic [3:0] model_out(input int off, input logic op,
                                             input int sw, input int pw);
        if (off >= 1 && off <= sw)            return {op, ~op, 1'b0, 1'b0};
        if (off > sw && off <= sw + pw)       return {op, ~op, 1'b1, 1'b0};
        if (off == sw + pw + 1)               return {op, ~op, 1'b0, 1'b0};
        if (off == sw + pw + 2)               return 4'b0001;
        return 4'b0000;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        req0_valid = 0; req1_valid = 0; b_req0_valid = 0; b_req1_valid = 0;
        rst = 1;
        repeat (2) @(posedge clk);
        #1;
        rst = 0;
    endtask

    task automatic drain(input bit second);
        bit ok = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (!(second ? b_busy : busy)) begin ok = 1; break; end
            tick();
        end
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL drain_timeout: busy still %0b, required 0", second ? b_busy : busy);
        end
        tick();
    endtask

    task automatic test_reset();
        @(negedge clk);
        req0_valid = 1; req0_op = 1; req1_valid = 1; req1_op = 0;
        #1;
        checks++;
        if ({S, R, Enable, busy, done, done_id, err} !== 7'b0) begin
            errors++;
            $display("FAIL reset_outputs: got %b, required 0000000",
                     {S, R, Enable, busy, done, done_id, err});
        end
        checks++;
        if ({b_S, b_R, b_Enable, b_busy, b_done, b_done_id, b_err} !== 7'b0) begin
            errors++;
            $display("FAIL reset_outputs_dut2: got %b, required 0000000",
                     {b_S, b_R, b_Enable, b_busy, b_done, b_done_id, b_err});
        end
        @(posedge clk); #1;
        rst = 0;
        @(negedge clk);
        checks++;
        if ({req0_ready, req1_ready} !== 2'b10) begin
            errors++;
            $display("FAIL first_grant: ready0/1 got %b, required 10", {req0_ready, req1_ready});
        end
        tick();
        req0_valid = 0; req1_valid = 0;
        @(negedge clk);
        checks++;
        if ({busy, S, R} !== 3'b110) begin
            errors++;
            $display("FAIL first_handshake_setup: busy/S/R got %b, required 110", {busy, S, R});
        end
        tick();
        drain(0);
    endtask

    task automatic test_single_set();
        apply_reset();
        req0_valid = 1; req0_op = 1;
        @(negedge clk);
        checks++;
        if (req0_ready !== 1'b1) begin
            errors++; $display("FAIL single_ready: got %b, required 1", req0_ready);
        end
        for (int off = 1; off <= 8; off++) begin
            tick();
            if (off == 1) req0_valid = 0;
            if (off == 6) begin req0_valid = 1; req0_op = 0; end
            @(negedge clk);
            if (off <= 7) begin
                checks++;
                if ({S, R, Enable, done} !== model_out(off, 1'b1, 1, 2)) begin
                    errors++;
                    $display("FAIL single_wave off=%0d: S/R/En/done got %b, required %b",
                             off, {S, R, Enable, done}, model_out(off, 1'b1, 1, 2));
                end
            end
            if (off == 5) begin
                checks++;
                if ({done_id, Qa, err} !== 3'b010) begin
                    errors++;
                    $display("FAIL single_done: done_id/Qa/err got %b, required 010", {done_id, Qa, err});
                end
            end
            if (off >= 6) begin
                checks++;
                if (req0_ready !== (off == 8)) begin
                    errors++;
                    $display("FAIL single_next_ready off=%0d: got %b, required %b", off, req0_ready, off == 8);
                end
            end
        end
        tick();
        req0_valid = 0;
        drain(0);
    endtask

    task automatic test_contention();
        apply_reset();
        req0_valid = 1; req0_op = 1; req1_valid = 1; req1_op = 0;
        @(negedge clk);
        checks++;
        if ({req0_ready, req1_ready} !== 2'b10) begin
            errors++; $display("FAIL contention_grant: got %b, required 10", {req0_ready, req1_ready});
        end
        for (int off = 1; off <= 13; off++) begin
            tick();
            if (off == 1) req0_valid = 0;
            if (off == 9) req1_valid = 0;
            @(negedge clk);
            if (off <= 8) begin
                checks++;
                if (req1_ready !== (off == 8)) begin
                    errors++;
                    $display("FAIL contention_wait off=%0d: ready1 got %b, required %b", off, req1_ready, off == 8);
                end
            end
            if (off == 5) begin
                checks++;
                if ({done, done_id, Qa} !== 3'b101) begin
                    errors++; $display("FAIL contention_done0: got %b, required 101", {done, done_id, Qa});
                end
            end
            if (off == 13) begin
                checks++;
                if ({done, done_id, Qa} !== 3'b110) begin
                    errors++; $display("FAIL contention_done1: got %b, required 110", {done, done_id, Qa});
                end
            end
        end
        tick();
        drain(0);
    endtask

    task automatic test_alternation();
        int grants[$];
        apply_reset();
        req0_valid = 1; req0_op = 1; req1_valid = 1; req1_op = 0;
        for (int i = 0; i < 60 && grants.size() < 3; i++) begin
            @(negedge clk);
            if (req0_valid && req0_ready) grants.push_back(0);
            if (req1_valid && req1_ready) grants.push_back(1);
            tick();
        end
        req0_valid = 0; req1_valid = 0;
        checks++;
        if (grants.size() != 3) begin
            errors++; $display("FAIL alternation_count: got %0d grants, required 3", grants.size());
        end else begin
            checks++;
            if (grants[0] != 0 || grants[1] != 1 || grants[2] != 0) begin
                errors++;
                $display("FAIL alternation_order: got %0d,%0d,%0d, required 0,1,0",
                         grants[0], grants[1], grants[2]);
            end
        end
        drain(0);
    endtask

    task automatic test_stuck();
        bit seen;
        apply_reset();
        stuck0 = 1;
        req0_valid = 1; req0_op = 1;
        tick();
        req0_valid = 0;
        for (int off = 1; off <= 6; off++) begin
            @(negedge clk);
            if (off == 5) begin
                checks++;
                if ({done, err, Qa} !== 3'b110) begin
                    errors++; $display("FAIL stuck_check: done/err/Qa got %b, required 110", {done, err, Qa});
                end
            end
            tick();
        end
        stuck0 = 0;
        drain(0);
        req1_valid = 1; req1_op = 1;
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (req1_ready) begin
                tick(); req1_valid = 0;
                @(negedge clk);
            end
            if (done) begin seen = 1; break; end
            tick();
        end
        checks++;
        if (!seen || {err, Qa, done_id} !== 3'b111) begin
            errors++;
            $display("FAIL stuck_sticky: seen=%0b err/Qa/done_id got %b, required 111", seen, {err, Qa, done_id});
        end
        tick();
        drain(0);
        apply_reset();
        @(negedge clk);
        checks++;
        if (err !== 1'b0) begin
            errors++; $display("FAIL stuck_clear: err got %b, required 0", err);
        end
        tick();
    endtask

    task automatic test_reset_mid();
        apply_reset();
        req0_valid = 1; req0_op = 1;
        tick();
        req0_valid = 0;
        tick();
        @(negedge clk);
        checks++;
        if (Enable !== 1'b1) begin
            errors++; $display("FAIL midrst_pulse: Enable got %b, required 1", Enable);
        end
        #1 rst = 1;
        #1;
        checks++;
        if ({S, R, Enable, busy, done} !== 5'b0) begin
            errors++; $display("FAIL midrst_async: got %b, required 00000", {S, R, Enable, busy, done});
        end
        repeat (3) begin
            tick();
            @(negedge clk);
            checks++;
            if (done !== 1'b0) begin
                errors++; $display("FAIL midrst_nodone: done got %b, required 0", done);
            end
        end
        tick();
        rst = 0;
        req1_valid = 1; req1_op = 0;
        @(negedge clk);
        checks++;
        if (req1_ready !== 1'b1) begin
            errors++; $display("FAIL midrst_accept: ready1 got %b, required 1", req1_ready);
        end
        for (int off = 1; off <= 5; off++) begin
            tick();
            req1_valid = 0;
        end
        @(negedge clk);
        checks++;
        if ({done, done_id, Qa} !== 3'b110) begin
            errors++; $display("FAIL midrst_done: got %b, required 110", {done, done_id, Qa});
        end
        tick();
        drain(0);
    endtask

    task automatic test_short_params();
        apply_reset();
        b_req0_valid = 1; b_req0_op = 1;
        @(negedge clk);
        checks++;
        if (b_req0_ready !== 1'b1) begin
            errors++; $display("FAIL short_ready: got %b, required 1", b_req0_ready);
        end
        for (int off = 1; off <= 8; off++) begin
            tick();
            if (off == 1) b_req0_valid = 0;
            if (off == 7) begin b_req0_valid = 1; b_req0_op = 0; end
            @(negedge clk);
            checks++;
            if ({b_S, b_R, b_Enable, b_done} !== model_out(off, 1'b1, 3, 1)) begin
                errors++;
                $display("FAIL short_wave off=%0d: got %b, required %b",
                         off, {b_S, b_R, b_Enable, b_done}, model_out(off, 1'b1, 3, 1));
            end
            if (off >= 7) begin
                checks++;
                if (b_req0_ready !== (off == 8)) begin
                    errors++;
                    $display("FAIL short_next_ready off=%0d: got %b, required %b", off, b_req0_ready, off == 8);
                end
            end
        end
        tick();
        b_req0_valid = 0;
        drain(1);
    endtask

    task automatic test_random();
        int off = 0, cid = 0, last = 1, win;
        logic cop = 0, p0 = 0, p1 = 0, o0 = 0, o1 = 0;
        logic [6:0] got, exp;
        apply_reset();
        for (int cyc = 0; cyc < 400; cyc++) begin
            if (!p0 && $urandom_range(0, 2) == 0) begin p0 = 1; o0 = 1'($urandom_range(0, 1)); end
            if (!p1 && $urandom_range(0, 2) == 0) begin p1 = 1; o1 = 1'($urandom_range(0, 1)); end
            req0_valid = p0; req0_op = o0; req1_valid = p1; req1_op = o1;
            @(negedge clk);
            win = -1;
            got = {req0_ready, req1_ready, busy, S, R, Enable, done};
            if (off == 0) begin
                if (p0 && p1) win = 1 - last;
                else if (p0) win = 0;
                else if (p1) win = 1;
                exp = {win == 0, win == 1, 5'b00000};
            end else begin
                exp = {2'b00, 1'b1, model_out(off, cop, 1, 2)};
            end
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL random_cycle %0d: rdy0/rdy1/busy/S/R/En/done got %b, required %b", cyc, got, exp);
            end
            if (exp[0]) begin
                checks++;
                if ({done_id, Qa, err} !== {cid[0], cop, 1'b0}) begin
                    errors++;
                    $display("FAIL random_done %0d: done_id/Qa/err got %b, required %b",
                             cyc, {done_id, Qa, err}, {cid[0], cop, 1'b0});
                end
            end
            tick();
            if (off == 0) begin
                if (win >= 0) begin
                    off = 1; cid = win; last = win;
                    cop = (win == 1) ? o1 : o0;
                    if (win == 0) p0 = 0; else p1 = 0;
                end
            end else begin
                off++;
                if (off > 7) off = 0;
            end
        end
        req0_valid = 0; req1_valid = 0;
        drain(0);
    endtask

    initial begin
        test_reset();
        test_single_set();
        test_contention();
        test_alternation();
        test_stuck();
        test_reset_mid();
        test_short_params();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not complete, required completion");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/sr_latch_sequencer.md
SR_LATCH_SEQUENCER -- requirements
Module: sr_latch_sequencer

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset, named clk and rst.
REQ-002 The block SHALL have parameter SETUP_W, default 1: cycles S/R are driven before Enable rises; legal range 1..15.
REQ-003 The block SHALL have parameter PULSE_W, default 2: cycles Enable is high; legal range 1..15.
REQ-004 The block SHALL have parameter GAP_W, default 2: idle cycles after each operation; legal range 1..15.
REQ-005 Port clk  in  1  shall be the rising-edge clock.
REQ-006 Port rst  in  1  shall be the async active-high reset.
REQ-007 Ports req0_valid, req1_valid  in  1 each  shall be requester command valid.
REQ-008 Ports req0_op, req1_op  in  1 each  shall select the operation: 1 = set, 0 = reset.
REQ-009 Ports req0_ready, req1_ready  out  1 each  shall accept the command; transfer occurs when valid && ready.
REQ-010 Ports S, R, Enable  out  1 each  shall drive the gated SR latch.
REQ-011 Port Qa  in  1  shall be the latch output feedback.
REQ-012 Port busy  out  1  shall be high in every state except IDLE.
REQ-013 Port done  out  1  shall be a one-cycle pulse at operation completion.
REQ-014 Port done_id  out  1  shall give the requester index of the completed operation, valid with done.
REQ-015 Port err  out  1  shall be a sticky flag for a Qa mismatch.

Function
REQ-016 The FSM SHALL use states IDLE, SETUP, PULSE, HOLD, CHECK and GAP.
REQ-017 In IDLE with any valid input, the block SHALL drive ready combinationally to exactly one winner; the loser's ready SHALL stay 0.
REQ-018 Arbitration SHALL be round-robin over 2 requesters: on simultaneous valid, the winner is the requester not granted last; last_grant resets to 1, so req0 wins first.
REQ-019 On transfer, the block SHALL latch op and id, then go IDLE->SETUP.
REQ-020 In SETUP, the block SHALL drive S=op, R=~op and Enable=0 for SETUP_W cycles, then go to PULSE.
REQ-021 In PULSE, the block SHALL hold S/R and drive Enable=1 for PULSE_W cycles, then go to HOLD.
REQ-022 In HOLD, the block SHALL drive Enable=0 and hold S/R for 1 cycle, then go to CHECK.
REQ-023 In CHECK, the block SHALL drive S=R=Enable=0, pulse done with done_id, set err if Qa != op, then go to GAP.
REQ-024 In GAP, the block SHALL drive all latch outputs 0 for GAP_W cycles, then go to IDLE.
REQ-025 S and R SHALL never be 1 in the same cycle, and Enable SHALL be 1 only in PULSE.
REQ-026 All latch outputs SHALL be registered, with no combinational path from the req inputs to S/R/Enable.
REQ-027 With defaults, a handshake at cycle T SHALL produce done at T+5 and earliest next ready at T+8.
REQ-028 Redundant operations (set while already set) SHALL be fully sequenced with no skip.
REQ-029 Requests arriving while busy SHALL wait with ready=0, and valid SHALL be held by the requester.
REQ-030 Once set, err SHALL stay 1 until rst.
REQ-031 The internal state counter SHALL be 4 bits, reload on each state entry, and never wrap.

Reset
REQ-032 While rst=1, asynchronously: state=IDLE, S=R=Enable=0, busy=0, done=0, done_id=0, err=0, last_grant=1, counter=0.
REQ-033 A reset mid-operation SHALL abandon the operation, with no done pulse and Enable dropping immediately.
REQ-034 The first handshake SHALL be possible in the first clk edge after rst deasserts.

Structure
REQ-035 State encodings (3-bit) and the OP_SET/OP_RESET constants SHALL live in a shared package or include file, sr_seq_pkg.
REQ-036 The round-robin grant logic SHALL be a sub-module, rr_arb2 (inputs req[1:0] and last_grant; outputs gnt[1:0] and gnt_id).
REQ-037 The rest of the block SHALL be a single FSM, a pulse counter and output registers.

Verification
REQ-038 The bench SHALL instantiate the sequencer driving a behavioral gated SR latch, with Qa fed back.
REQ-039 Scenario: req0 set at T -> S=1 at T+1, Enable=1 at T+2..T+3, Qa=1, done=1 and done_id=0 at T+5, err=0.
REQ-040 Scenario: req0 and req1 valid together (req1 reset) -> req0 served first, req1 ready at T+8, Qa=0 after second done, done_id=1.
REQ-041 Scenario: req1 valid continuously with req0 set -> grants alternate 0,1,0 with no starvation.
REQ-042 Scenario: latch model forced to stick at 0 during a set -> err=1 at CHECK and remains 1 through later good ops until rst.
REQ-043 Scenario: rst asserted during PULSE -> Enable=S=R=0 the same cycle, no done pulse, next request accepted normally.
REQ-044 Scenario: SETUP_W=3, PULSE_W=1, GAP_W=1 -> done at T+6 and next ready at T+8, and S&R is never 1 across the run (assertion).
